raster_scan: RTL and testbench
==============================

Name: raster_scan

Overview:
- Downstream consumer of the clip/split stage's triangle_ready/triangle_read handshake.
- Accepts one screen-space triangle plus its colour and computes a screen-clamped integer bounding box.
- Emits every pixel coordinate in that box, in raster order, over a valid/accept stream to the fragment/edge-test stage.
- Culls triangles whose bounding box lies fully off-screen.

Parameters:
SCREEN_W, 640, screen width in pixels; valid x range 0..SCREEN_W-1
SCREEN_H, 480, screen height in pixels; valid y range 0..SCREEN_H-1
COORD_W, 16, width of signed integer vertex x/y and of pixel_x/pixel_y

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
triangle_ready  in  1  upstream holds a valid triangle until it is read
triangle_vertices_in  in  Triangle3D  three vertices; x/y fields are signed COORD_W integer pixels
triangle_color_in  in  Color  flat colour of triangle
triangle_read  out  1  one-cycle consume pulse to upstream
pixel_valid  out  1  pixel_x/pixel_y/pixel_color/pixel_last valid
pixel_accept  in  1  downstream takes pixel when pixel_valid && pixel_accept
pixel_x  out  COORD_W  pixel column
pixel_y  out  COORD_W  pixel row
pixel_color  out  Color  latched triangle colour
pixel_last  out  1  final pixel of current triangle
busy  out  1  state != IDLE
culled  out  1  one-cycle pulse when a triangle is dropped as off-screen

Behaviour:
- Reset: state=IDLE; all outputs 0; internal registers (bbox, x/y counters, latched triangle, colour) 0. Reset mid-scan abandons the triangle, with no further pixels or pulses.
- States are IDLE, FETCH, BBOX, SCAN.
- IDLE: triangle_ready=1 -> FETCH, else stay.
- FETCH: triangle_read=1 for exactly this cycle; vertices and colour latched at its clock edge; -> BBOX. If triangle_ready=0 in FETCH: triangle_read=0, no latch, -> IDLE.
- BBOX:
  - minx=max(0, min(x0,x1,x2)); maxx=min(SCREEN_W-1, max(x0,x1,x2)); same for y with SCREEN_H.
  - All comparisons are signed, COORD_W bits. Results are registered.
  - Cull if min(x0,x1,x2) > SCREEN_W-1, max(x0,x1,x2) < 0, min(y0,y1,y2) > SCREEN_H-1, or max(y0,y1,y2) < 0. The test uses the unclamped extrema, so it is equivalent to minx>maxx || miny>maxy after clamping.
  - On cull: culled=1 for one cycle, -> IDLE.
  - Otherwise: cur_x=minx, cur_y=miny, -> SCAN.
- SCAN:
  - pixel_valid=1, pixel_x=cur_x, pixel_y=cur_y, pixel_color=latched colour.
  - pixel_last=(cur_x==maxx && cur_y==maxy).
  - Outputs hold stable while pixel_accept=0.
  - On accept: if last -> IDLE (pixel_valid low next cycle); elif cur_x==maxx -> cur_x=minx, cur_y+1; else cur_x+1.
- Latency: triangle_ready seen in IDLE at cycle T -> triangle_read at T+1 -> first pixel_valid at T+3. Back-to-back triangles incur 3 idle output cycles between the last accept and the next first pixel.
- Throughput: one pixel per cycle under continuous accept. Pixel count = (maxx-minx+1)*(maxy-miny+1).
- Degenerate cases:
  - Zero-area or collinear triangles are not culled here; the box is scanned.
  - Single-pixel box: one pixel with pixel_last=1.
- triangle_ready is ignored outside IDLE/FETCH; triangle_read is never asserted outside FETCH.

Decomposition:
- Shared package (defines_package) holds:
  - Triangle3D and Color typedefs.
  - A new scan-state enum, distinct from the existing states type.
  - SCREEN_W/SCREEN_H defaults as package constants.
- One combinational sub-module, bbox_calc: min3/max3 of the three coordinates, clamp, and off-screen flag, instanced once for x and once for y.

Test Plan:
- Vertices (2,3),(4,3),(2,4), accept tied 1 -> triangle_read pulse at T+1; 6 pixels in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4); pixel_last only on (4,4); busy low the cycle after.
- Vertices (-5,-5),(1,-2),(0,1) -> clamped box x0..1, y0..1; 4 pixels (0,0)(1,0)(0,1)(1,1).
- Vertices (700,10),(800,20),(650,30), SCREEN_W=640 -> culled pulse 1 cycle, zero pixel_valid, back to IDLE by T+3.
- All vertices (7,9) -> single pixel (7,9) with pixel_last=1.
- Box 3x2 with pixel_accept toggling 1,0,0,1,... -> pixel_x/y/color stable while accept=0; no pixel dropped or duplicated; 6 transfers total.
- Assert n_rst low after 2nd accepted pixel -> all outputs 0 immediately; after release, a new triangle scans from its own minx/miny.

Source files
------------

// File: rtl/defines_package.sv
// Shared types and constants for the raster front end: triangle/colour payloads,
// screen defaults and the scan-converter state encoding.
package defines_package;

  localparam int COORD_W_DEF      = 16;
  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D [2:0] v;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  // Scan-converter states; kept separate from the upstream pipeline's own states type.
  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_FETCH = 2'd1,
    SCAN_BBOX  = 2'd2,
    SCAN_SCAN  = 2'd3
  } scan_state_t;

  function automatic coord_t min2(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t max2(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/raster_scan_bbox_calc.sv
// One axis of the bounding box: signed extrema of three coordinates, clamped to
// 0..LIMIT, plus a flag when the unclamped span lies entirely outside that range.
module bbox_calc
  import defines_package::*;
#(
  parameter int LIMIT = SCREEN_W_DEFAULT - 1
) (
  input  coord_t a_i,
  input  coord_t b_i,
  input  coord_t c_i,
  output coord_t lo_o,
  output coord_t hi_o,
  output logic   off_o
);

  localparam coord_t LIM  = coord_t'(LIMIT);
  localparam coord_t ZERO = '0;

  coord_t mn;
  coord_t mx;

  always_comb begin
    mn    = min2(min2(a_i, b_i), c_i);
    mx    = max2(max2(a_i, b_i), c_i);
    // Off-screen test uses the raw extrema so it never depends on the clamp.
    off_o = (mn > LIM) || (mx < ZERO);
    lo_o  = (mn < ZERO) ? ZERO : mn;
    hi_o  = (mx > LIM) ? LIM : mx;
  end

endmodule

// File: rtl/raster_scan.sv
// Triangle bounding-box raster scanner: fetches one triangle, clamps its box to
// the screen, culls it if fully off-screen, else streams every box pixel in raster order.
module raster_scan
  import defines_package::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      triangle_ready,
  input  Triangle3D                 triangle_vertices_in,
  input  Color                      triangle_color_in,
  output logic                      triangle_read,
  output logic                      pixel_valid,
  input  logic                      pixel_accept,
  output logic signed [COORD_W-1:0] pixel_x,
  output logic signed [COORD_W-1:0] pixel_y,
  output Color                      pixel_color,
  output logic                      pixel_last,
  output logic                      busy,
  output logic                      culled
);

  scan_state_t state_q;
  Triangle3D   tri_q;
  Color        color_q;
  coord_t      minx_q, maxx_q, miny_q, maxy_q;
  coord_t      cur_x_q, cur_y_q;

  coord_t xlo, xhi, ylo, yhi;
  logic   xoff, yoff;
  logic   cull;
  logic   at_row_end;
  logic   at_last;

  bbox_calc #(.LIMIT(SCREEN_W - 1)) u_bbox_x (
    .a_i  (tri_q.v[0].x),
    .b_i  (tri_q.v[1].x),
    .c_i  (tri_q.v[2].x),
    .lo_o (xlo),
    .hi_o (xhi),
    .off_o(xoff)
  );

  bbox_calc #(.LIMIT(SCREEN_H - 1)) u_bbox_y (
    .a_i  (tri_q.v[0].y),
    .b_i  (tri_q.v[1].y),
    .c_i  (tri_q.v[2].y),
    .lo_o (ylo),
    .hi_o (yhi),
    .off_o(yoff)
  );

  assign cull       = xoff || yoff;
  assign at_row_end = (cur_x_q == maxx_q);
  assign at_last    = at_row_end && (cur_y_q == maxy_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= SCAN_IDLE;
      tri_q   <= '0;
      color_q <= '0;
      minx_q  <= '0;
      maxx_q  <= '0;
      miny_q  <= '0;
      maxy_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          if (triangle_ready) state_q <= SCAN_FETCH;
        end
        SCAN_FETCH: begin
          // Upstream may withdraw between IDLE and FETCH; only latch on a real read.
          if (triangle_ready) begin
            tri_q   <= triangle_vertices_in;
            color_q <= triangle_color_in;
            state_q <= SCAN_BBOX;
          end else begin
            state_q <= SCAN_IDLE;
          end
        end
        SCAN_BBOX: begin
          minx_q <= xlo;
          maxx_q <= xhi;
          miny_q <= ylo;
          maxy_q <= yhi;
          if (cull) begin
            state_q <= SCAN_IDLE;
          end else begin
            cur_x_q <= xlo;
            cur_y_q <= ylo;
            state_q <= SCAN_SCAN;
          end
        end
        SCAN_SCAN: begin
          if (pixel_accept) begin
            if (at_last) begin
              state_q <= SCAN_IDLE;
            end else if (at_row_end) begin
              cur_x_q <= minx_q;
              cur_y_q <= cur_y_q + coord_t'(1);
            end else begin
              cur_x_q <= cur_x_q + coord_t'(1);
            end
          end
        end
        default: state_q <= SCAN_IDLE;
      endcase
    end
  end

  // All outputs derive from registered state, so they read 0 while reset is held.
  assign triangle_read = (state_q == SCAN_FETCH) && triangle_ready;
  assign culled        = (state_q == SCAN_BBOX) && cull;
  assign busy          = (state_q != SCAN_IDLE);
  assign pixel_valid   = (state_q == SCAN_SCAN);
  assign pixel_last    = (state_q == SCAN_SCAN) && at_last;
  assign pixel_x       = cur_x_q;
  assign pixel_y       = cur_y_q;
  assign pixel_color   = color_q;

endmodule

// File: tb/tb_raster_scan.sv
// Bench for raster_scan: table of triangles with hand-computed results, random
// triangles against a bounding-box reference model, and a mid-scan reset sequence.
module tb_raster_scan;
  import defines_package::*;

  localparam int SW = 640;
  localparam int SH = 480;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               triangle_ready;
  Triangle3D          tri_in;
  Color               col_in;
  logic               triangle_read;
  logic               pixel_valid;
  logic               pixel_accept;
  logic signed [15:0] pixel_x;
  logic signed [15:0] pixel_y;
  Color               pixel_color;
  logic               pixel_last;
  logic               busy;
  logic               culled;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  raster_scan dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .triangle_ready      (triangle_ready),
    .triangle_vertices_in(tri_in),
    .triangle_color_in   (col_in),
    .triangle_read       (triangle_read),
    .pixel_valid         (pixel_valid),
    .pixel_accept        (pixel_accept),
    .pixel_x             (pixel_x),
    .pixel_y             (pixel_y),
    .pixel_color         (pixel_color),
    .pixel_last          (pixel_last),
    .busy                (busy),
    .culled              (culled)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, pixel_valid, 0);
    check({tag, "_last"}, pixel_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_culled"}, culled, 0);
    check({tag, "_read"}, triangle_read, 0);
    check({tag, "_x"}, pixel_x, 0);
    check({tag, "_y"}, pixel_y, 0);
    check({tag, "_color"}, pixel_color, 0);
  endtask

  // mode: 0 = accept always, 1 = accept pattern 1,0,0 repeating, 2 = random accept.
  // abort_after > 0 pulls reset once that many pixels have been taken.
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input logic [23:0] col,
                         input int mode, input int abort_after,
                         output int ntx, output int ncull, output int fx, output int fy);
    int mnx, mxx, mny, mxy, lox, hix, loy, hiy;
    bit cull, acc, hold, done;
    int ex[$];
    int ey[$];
    int rd_at, fv_at, idx;
    int px, py;
    logic [23:0] pc;
    Triangle3D t;

    // Reference: clamped bounding box and the list of pixels in raster order.
    mnx = (x0 < x1) ? x0 : x1; mnx = (x2 < mnx) ? x2 : mnx;
    mxx = (x0 > x1) ? x0 : x1; mxx = (x2 > mxx) ? x2 : mxx;
    mny = (y0 < y1) ? y0 : y1; mny = (y2 < mny) ? y2 : mny;
    mxy = (y0 > y1) ? y0 : y1; mxy = (y2 > mxy) ? y2 : mxy;
    lox = (mnx < 0) ? 0 : mnx;  hix = (mxx > SW - 1) ? SW - 1 : mxx;
    loy = (mny < 0) ? 0 : mny;  hiy = (mxy > SH - 1) ? SH - 1 : mxy;
    cull = (lox > hix) || (loy > hiy);
    if (!cull)
      for (int yy = loy; yy <= hiy; yy++)
        for (int xx = lox; xx <= hix; xx++) begin
          ex.push_back(xx);
          ey.push_back(yy);
        end

    ntx = 0; ncull = 0; fx = -1; fy = -1;
    t = '0;
    t.v[0].x = coord_t'(x0); t.v[0].y = coord_t'(y0);
    t.v[1].x = coord_t'(x1); t.v[1].y = coord_t'(y1);
    t.v[2].x = coord_t'(x2); t.v[2].y = coord_t'(y2);

    @(negedge clk);
    tri_in = t;
    col_in = col;
    triangle_ready = 1'b1;
    pixel_accept = 1'b0;
    rd_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (triangle_read) begin
        rd_at = k;
        break;
      end
    end
    check("read_latency", rd_at, 1);
    if (rd_at < 0) begin
      triangle_ready = 1'b0;
      return;
    end
    @(negedge clk);
    check("read_one_cycle", triangle_read, 0);
    triangle_ready = 1'b0;
    tri_in = '0;
    col_in = '0;

    idx = 0; fv_at = -1; hold = 0; done = 0;
    px = 0; py = 0; pc = '0;
    for (int c = 0; c < 4000; c++) begin
      if (culled) begin
        ncull++;
        done = 1;
      end
      if (hold) begin
        check("hold_stable",
              {pixel_valid, (pixel_x == px), (pixel_y == py), (pixel_color == pc)}, 4'b1111);
      end
      if (pixel_valid && fv_at < 0) fv_at = c;
      case (mode)
        0:       acc = 1'b1;
        1:       acc = (fv_at >= 0) && (((c - fv_at) % 3) == 0);
        default: acc = ($urandom_range(0, 3) != 0);
      endcase
      pixel_accept = acc;
      hold = pixel_valid && !acc;
      px = pixel_x; py = pixel_y; pc = pixel_color;
      if (pixel_valid && acc) begin
        if (idx < ex.size()) begin
          total++;
          if (pixel_x != ex[idx] || pixel_y != ey[idx] || pixel_color != col ||
              pixel_last != (idx == ex.size() - 1)) begin
            bad++;
            $display("FAIL pixel[%0d]: got (%0d,%0d) col=%h last=%0d, expected (%0d,%0d) col=%h last=%0d",
                     idx, pixel_x, pixel_y, pixel_color, pixel_last,
                     ex[idx], ey[idx], col, (idx == ex.size() - 1));
          end
        end else begin
          check("extra_pixel", idx, ex.size() - 1);
        end
        if (idx == 0) begin
          fx = pixel_x;
          fy = pixel_y;
        end
        idx++;
        ntx++;
        if (pixel_last) done = 1;
        if (abort_after > 0 && idx == abort_after) begin
          @(negedge clk);
          pixel_accept = 1'b0;
          n_rst = 1'b0;
          #1;
          check_outputs_zero("abort_rst");
          @(negedge clk);
          check_outputs_zero("abort_hold");
          n_rst = 1'b1;
          return;
        end
      end
      if (done) break;
      @(negedge clk);
    end
    check("scan_finished", done, 1);
    @(negedge clk);
    pixel_accept = 1'b0;
    check("busy_after", busy, 0);
    check("valid_after", pixel_valid, 0);
    check("pix_count", idx, ex.size());
    check("cull_pulses", ncull, cull ? 1 : 0);
    check("first_valid_at", fv_at, cull ? -1 : 1);
  endtask

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int mode;
    int cnt;
    int cull;
    int fx, fy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int ntx, nc, fx, fy;
    logic [23:0] col;

    tbl[0] = '{2, 3, 4, 3, 2, 4, 0, 6, 0, 2, 3};
    tbl[1] = '{-5, -5, 1, -2, 0, 1, 0, 4, 0, 0, 0};
    tbl[2] = '{700, 10, 800, 20, 650, 30, 0, 0, 1, -1, -1};
    tbl[3] = '{7, 9, 7, 9, 7, 9, 0, 1, 0, 7, 9};
    tbl[4] = '{10, 20, 12, 20, 10, 21, 1, 6, 0, 10, 20};
    tbl[5] = '{630, 470, 700, 500, 635, 475, 2, 100, 0, 630, 470};
    tbl[6] = '{-10, -3, -1, 5, -4, 2, 0, 0, 1, -1, -1};
    tbl[7] = '{5, 480, 6, 490, 7, 481, 0, 0, 1, -1, -1};

    n_rst = 1'b0;
    triangle_ready = 1'b0;
    pixel_accept = 1'b0;
    tri_in = '0;
    col_in = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      col = 24'($urandom);
      run_tri(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2,
              col, tbl[i].mode, 0, ntx, nc, fx, fy);
      check($sformatf("tbl%0d_count", i), ntx, tbl[i].cnt);
      check($sformatf("tbl%0d_cull", i), nc, tbl[i].cull);
      check($sformatf("tbl%0d_fx", i), fx, tbl[i].fx);
      check($sformatf("tbl%0d_fy", i), fy, tbl[i].fy);
    end

    // Reset after the second accepted pixel, then a fresh triangle from its own origin.
    run_tri(40, 50, 42, 50, 40, 51, 24'h123456, 0, 2, ntx, nc, fx, fy);
    check("abort_count", ntx, 2);
    @(negedge clk);
    check("abort_idle", busy, 0);
    run_tri(20, 30, 21, 30, 20, 31, 24'hABCDEF, 0, 0, ntx, nc, fx, fy);
    check("post_rst_count", ntx, 4);
    check("post_rst_fx", fx, 20);
    check("post_rst_fy", fy, 30);

    for (int r = 0; r < 25; r++) begin
      int bx, by;
      bx = int'($urandom_range(0, 720)) - 40;
      by = int'($urandom_range(0, 560)) - 40;
      col = 24'($urandom);
      run_tri(bx + int'($urandom_range(0, 8)), by + int'($urandom_range(0, 6)),
              bx + int'($urandom_range(0, 8)), by + int'($urandom_range(0, 6)),
              bx + int'($urandom_range(0, 8)), by + int'($urandom_range(0, 6)),
              col, 2, 0, ntx, nc, fx, fy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
